// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment readback path: glyph table (lit-high, A..G
// order), the blank pattern and the reader FSM states.
package disp_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    localparam logic [6:0] BLANK_GLYPH = 7'h00;

    // Raw {seg_n, dp_n} word for a fully dark display (active-low lines).
    localparam logic [7:0] DARK_SAMPLE = 8'hFF;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } rd_state_e;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/module_disp_reader_if.sv
// Segment-line inputs and decoded-report handshake of the display reader.
// The reader itself uses the slave modport; the consumer/stimulus side uses master.
interface module_disp_reader_if;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [4:0] code_out;
    logic       code_valid;
    logic       code_ack;
    logic       pat_err;
    logic       blank;
    logic       overrun;

    modport master (
        output seg_n, dp_n, code_ack,
        input  code_out, code_valid, pat_err, blank, overrun
    );

    modport slave (
        input  seg_n, dp_n, code_ack,
        output code_out, code_valid, pat_err, blank, overrun
    );
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational lookup of a lit-high 7-segment pattern (A..G) into a hex digit,
// with separate match and all-dark indications.
module seg_glyph_decode
    import disp_pkg::*;
(
    input  logic [6:0] lit,
    output logic       match,
    output logic       blank,
    output logic [3:0] digit
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hit
            assign hit[gi] = (lit == glyph(4'(gi)));
        end
    endgenerate

    // Glyphs are distinct, so at most one hit bit is ever set.
    always_comb begin
        digit = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                digit = 4'(i);
            end
        end
    end

    assign match = |hit;
    assign blank = (lit == BLANK_GLYPH);

endmodule

// File: rtl/module_disp_reader.sv
// Watches the active-low segment lines, waits for a stable pattern and reports
// the decoded display code through a valid/ack handshake.
module module_disp_reader
    import disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    module_disp_reader_if.slave  bus
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [7:0] smp_q, smp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_rep_q, last_rep_d;
    rd_state_e  state_q, state_d;
    logic [4:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       pat_err_q, pat_err_d;
    logic       blank_q, blank_d;
    logic       overrun_q, overrun_d;

    logic [7:0] in_word;
    logic       in_chg;
    logic       settled;
    logic       load;

    logic       dec_match;
    logic       dec_blank;
    logic [3:0] dec_digit;

    // The sample register holds active-low lines; the decoder wants lit-high.
    seg_glyph_decode u_decode (
        .lit   (~smp_q[7:1]),
        .match (dec_match),
        .blank (dec_blank),
        .digit (dec_digit)
    );

    always_comb begin
        in_word = {bus.seg_n, bus.dp_n};
        in_chg  = (in_word != smp_q);
        smp_d   = in_word;

        if (in_chg) begin
            cnt_d = 8'd0;
        end else if (cnt_q == STABLE_CNT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // A change on the settling edge wins: the held pattern still reports,
        // but the FSM keeps settling on the newly sampled one.
        settled = (state_q == SETTLE) && (cnt_q == STABLE_CNT);
        state_d = state_q;
        case (state_q)
            SETTLE: if (settled && !in_chg) state_d = HOLD;
            HOLD:   if (in_chg)             state_d = SETTLE;
            default:                        state_d = SETTLE;
        endcase

        load       = settled && (smp_q != last_rep_q);
        last_rep_d = settled ? smp_q : last_rep_q;

        code_d    = code_q;
        pat_err_d = pat_err_q;
        blank_d   = blank_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            code_d    = {~smp_q[0], dec_match ? dec_digit : 4'h0};
            pat_err_d = !dec_match && !dec_blank;
            blank_d   = dec_blank;
            valid_d   = 1'b1;
            if (valid_q && !bus.code_ack) begin
                overrun_d = 1'b1;
            end
        end else if (bus.code_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q      <= DARK_SAMPLE;
            cnt_q      <= 8'd0;
            last_rep_q <= DARK_SAMPLE;
            state_q    <= SETTLE;
            code_q     <= 5'd0;
            valid_q    <= 1'b0;
            pat_err_q  <= 1'b0;
            blank_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            smp_q      <= smp_d;
            cnt_q      <= cnt_d;
            last_rep_q <= last_rep_d;
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pat_err_q  <= pat_err_d;
            blank_q    <= blank_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.code_out   = code_q;
    assign bus.code_valid = valid_q;
    assign bus.pat_err    = pat_err_q;
    assign bus.blank      = blank_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_module_disp_reader.sv
// Bench for module_disp_reader: directed scenarios plus random segment traffic,
// compared every cycle against a timestamp-based reference model.
module tb_module_disp_reader;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    module_disp_reader_if bus ();

    module_disp_reader #(.STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference: a pattern reports once, S+1 edges after it was first sampled.
    int         cyc;
    int         t0;
    logic [7:0] m_smp;
    logic [7:0] m_last;
    logic [4:0] m_code;
    logic       m_valid, m_err, m_blank, m_ovr;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic [6:0] seg, input logic dp, input logic ack, input logic r);
        logic       do_load;
        logic [6:0] lit;
        cyc++;
        if (r) begin
            m_smp = 8'hFF; m_last = 8'hFF; t0 = cyc;
            m_code = 5'd0; m_valid = 0; m_err = 0; m_blank = 0; m_ovr = 0;
        end else begin
            do_load = (cyc - t0 == S + 1) && (m_smp != m_last);
            if (cyc - t0 == S + 1) m_last = m_smp;
            if (do_load) begin
                if (m_valid && !ack) m_ovr = 1;
                m_valid = 1;
                lit     = ~m_smp[7:1];
                m_code  = {~m_smp[0], 4'h0};
                m_err   = 1;
                m_blank = 0;
                for (int i = 0; i < 16; i++) begin
                    if (glyph_tab[i] == lit) begin
                        m_code[3:0] = 4'(i);
                        m_err = 0;
                    end
                end
                if (lit == 7'h00) begin
                    m_blank = 1;
                    m_err   = 0;
                end
                $display("report cycle=%0d seg_n=%h dp_n=%b code=%h err=%b blank=%b overrun=%b",
                         cyc, m_smp[7:1], m_smp[0], m_code, m_err, m_blank, m_ovr);
            end else if (ack && m_valid) begin
                m_valid = 0;
                m_ovr   = 0;
            end
            if ({seg, dp} != m_smp) begin
                m_smp = {seg, dp};
                t0    = cyc;
            end
        end
    endtask

    task automatic step(input logic [6:0] seg, input logic dp, input logic ack, input logic r);
        bus.seg_n    = seg;
        bus.dp_n     = dp;
        bus.code_ack = ack;
        rst          = r;
        @(posedge clk);
        model_edge(seg, dp, ack, r);
        #1;
        check_val("code_out",   {3'b0, bus.code_out}, {3'b0, m_code});
        check_val("code_valid", {7'b0, bus.code_valid}, {7'b0, m_valid});
        check_val("pat_err",    {7'b0, bus.pat_err}, {7'b0, m_err});
        check_val("blank",      {7'b0, bus.blank}, {7'b0, m_blank});
        check_val("overrun",    {7'b0, bus.overrun}, {7'b0, m_ovr});
    endtask

    task automatic hold(input logic [6:0] seg, input logic dp, input int n);
        for (int i = 0; i < n; i++) step(seg, dp, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] seg;
        logic       dp;
        int         kind;
        int         len;

        step(7'h7F, 1'b1, 1'b0, 1'b1);
        step(7'h7F, 1'b1, 1'b0, 1'b1);
        check_val("rst_valid", {7'b0, bus.code_valid}, 8'h00);
        check_val("rst_code",  {3'b0, bus.code_out}, 8'h00);
        hold(7'h7F, 1'b1, 8);
        check_val("dark_no_report", {7'b0, bus.code_valid}, 8'h00);

        // Digit 0: valid must rise exactly at edge E+5.
        hold(7'h01, 1'b1, 5);
        check_val("t1_not_yet", {7'b0, bus.code_valid}, 8'h00);
        hold(7'h01, 1'b1, 1);
        check_val("t1_valid", {7'b0, bus.code_valid}, 8'h01);
        check_val("t1_code",  {3'b0, bus.code_out}, 8'h00);
        step(7'h01, 1'b1, 1'b1, 1'b0);
        check_val("t1_acked", {7'b0, bus.code_valid}, 8'h00);

        // 8 with point, then ack and keep holding.
        hold(7'h00, 1'b0, 6);
        check_val("t2_code", {3'b0, bus.code_out}, 8'h18);
        step(7'h00, 1'b0, 1'b1, 1'b0);
        check_val("t2_drop", {7'b0, bus.code_valid}, 8'h00);
        hold(7'h00, 1'b0, 6);
        check_val("t2_no_rerise", {7'b0, bus.code_valid}, 8'h00);

        // Fast toggling never settles.
        for (int i = 0; i < 20; i++) begin
            hold((i % 2 == 0) ? 7'h4F : 7'h01, 1'b1, 2);
            check_val("t3_toggle", {7'b0, bus.code_valid}, 8'h00);
        end

        // Illegal glyph, then blank overwriting it without ack.
        hold(7'h37, 1'b1, 6);
        check_val("t4_err",  {7'b0, bus.pat_err}, 8'h01);
        check_val("t4_code", {4'b0, bus.code_out[3:0]}, 8'h00);
        hold(7'h7F, 1'b1, 6);
        check_val("t4_blank",   {7'b0, bus.blank}, 8'h01);
        check_val("t4_overrun", {7'b0, bus.overrun}, 8'h01);
        step(7'h7F, 1'b1, 1'b1, 1'b0);
        check_val("t4_ovr_clr", {7'b0, bus.overrun}, 8'h00);

        // New report loads on the same edge as the ack of the previous one.
        hold(7'h01, 1'b1, 6);
        hold(7'h4F, 1'b1, 5);
        step(7'h4F, 1'b1, 1'b1, 1'b0);
        check_val("t5_code",    {3'b0, bus.code_out}, 8'h01);
        check_val("t5_valid",   {7'b0, bus.code_valid}, 8'h01);
        check_val("t5_overrun", {7'b0, bus.overrun}, 8'h00);
        step(7'h4F, 1'b1, 1'b1, 1'b0);

        // Reset two cycles into settling.
        hold(7'h01, 1'b1, 6);
        step(7'h01, 1'b1, 1'b1, 1'b0);
        hold(7'h4F, 1'b1, 2);
        step(7'h4F, 1'b1, 1'b0, 1'b1);
        check_val("t6_code",  {3'b0, bus.code_out}, 8'h00);
        check_val("t6_valid", {7'b0, bus.code_valid}, 8'h00);
        hold(7'h7F, 1'b1, 8);
        check_val("t6_no_report", {7'b0, bus.code_valid}, 8'h00);

        // Random traffic.
        seg = 7'h7F;
        dp  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 8));
            if (kind < 6) begin
                seg = ~glyph_tab[$urandom_range(0, 15)];
                dp  = 1'($urandom_range(0, 1));
            end else if (kind == 6) begin
                seg = 7'h7F;
            end else if (kind == 7) begin
                seg = 7'($urandom);
            end else if (kind == 9) begin
                step(seg, dp, 1'b0, 1'b1);
            end
            for (int i = 0; i < len; i++) begin
                step(seg, dp, ($urandom_range(0, 3) == 0), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
